// File: rtl/alu_psr_if.sv
// alu_psr_if: request/response bundle for the registered ALU with status register.
//   in_valid/in_ready   operation handshake (master -> slave / slave -> master)
//   opcode, a, b        operation select and operands
//   psr_load, psr_din   direct PSR load
//   out_valid           one-cycle pulse when result/flags are fresh
//   result, flags       registered result and PSR contents {C, L, F, Z, N}
interface alu_psr_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             psr_load;
  logic [4:0]       psr_din;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;

  modport master (
    output in_valid, opcode, a, b, psr_load, psr_din,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, opcode, a, b, psr_load, psr_din,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_psr.sv
// alu_psr: registered ALU with a processor status register (PSR) and an iterative
// shift-add multiplier. Single-cycle ops update result/PSR on the accepting edge;
// MUL holds in_ready low while it iterates.
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    alu_psr_if slave: handshake, opcode/operands, PSR load, result/flags
module alu_psr #(
  parameter int unsigned WIDTH  = 16,
  parameter bit          MUL_EN = 1'b1
) (
  input logic      clk,
  input logic      reset,
  alu_psr_if.slave bus
);
  localparam logic [4:0] OpAnd   = 5'b00001;
  localparam logic [4:0] OpOr    = 5'b00010;
  localparam logic [4:0] OpXor   = 5'b00011;
  localparam logic [4:0] OpNot   = 5'b00100;
  localparam logic [4:0] OpAdd   = 5'b00101;
  localparam logic [4:0] OpAddu  = 5'b00110;
  localparam logic [4:0] OpAddc  = 5'b00111;
  localparam logic [4:0] OpSub   = 5'b01001;
  localparam logic [4:0] OpCmp   = 5'b01011;
  localparam logic [4:0] OpLsh   = 5'b01100;
  localparam logic [4:0] OpAddcu = 5'b01111;
  localparam logic [4:0] OpMul   = 5'b10000;
  localparam logic [4:0] OpRsh   = 5'b10011;
  localparam logic [4:0] OpArsh  = 5'b10111;

  // Counts multiplier bits still to be folded in after the accept edge.
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StMulRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       psr_q, psr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             accept;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] op_res;
  logic [4:0]       op_flags;
  logic             op_is_mul;
  logic [WIDTH-1:0] mul_sum;
  logic             flag_wr;
  logic [4:0]       flag_new;

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = psr_q;
  assign accept        = bus.in_valid && bus.in_ready;

  // The PSR register is written on the accepting edge, so an ADDC issued next cycle
  // already sees the new carry without extra forwarding.
  assign cin  = ((bus.opcode == OpAddc) || (bus.opcode == OpAddcu)) ? psr_q[4] : 1'b0;
  assign sum  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
  assign diff = bus.a - bus.b;

  // Single-cycle datapath; op_flags defaults to the current PSR so "flags unchanged"
  // ops and unknown opcodes need no separate write enable.
  always_comb begin
    op_res    = '0;
    op_flags  = psr_q;
    op_is_mul = 1'b0;
    case (bus.opcode)
      OpAdd, OpAddc: begin
        op_res   = sum[WIDTH-1:0];
        op_flags = {sum[WIDTH], 1'b0,
                    (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]),
                    ~|sum[WIDTH-1:0], sum[WIDTH-1]};
      end
      OpAddu, OpAddcu: op_res = sum[WIDTH-1:0];
      OpSub: begin
        op_res   = diff;
        op_flags = {bus.a < bus.b, 1'b0,
                    (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]),
                    ~|diff, diff[WIDTH-1]};
      end
      OpCmp: begin
        op_res   = '0;
        op_flags = {1'b0, bus.a < bus.b, 1'b0, bus.a == bus.b,
                    $signed(bus.a) < $signed(bus.b)};
      end
      OpAnd: op_res = bus.a & bus.b;
      OpOr:  op_res = bus.a | bus.b;
      OpXor: op_res = bus.a ^ bus.b;
      OpNot: op_res = ~bus.a;
      // SV shifts already give 0 / full sign fill for amounts >= WIDTH.
      OpLsh:  op_res = bus.a << bus.b;
      OpRsh:  op_res = bus.a >> bus.b;
      OpArsh: op_res = $signed(bus.a) >>> bus.b;
      OpMul: begin
        if (MUL_EN) op_is_mul = 1'b1;
      end
      default: ;
    endcase
  end

  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    flag_wr     = 1'b0;
    flag_new    = psr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (op_is_mul) begin
            // Bit 0 is folded in on the accept edge so the last of the WIDTH bits
            // lands WIDTH-1 edges later, giving out_valid WIDTH cycles after accept.
            acc_d    = bus.b[0] ? bus.a : '0;
            mcand_d  = bus.a << 1;
            mplier_d = bus.b >> 1;
            cnt_d    = CntW'(WIDTH - 1);
            state_d  = StMulRun;
          end else begin
            result_d    = op_res;
            out_valid_d = 1'b1;
            flag_wr     = 1'b1;
            flag_new    = op_flags;
          end
        end
      end
      StMulRun: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          result_d    = mul_sum;
          out_valid_d = 1'b1;
          flag_wr     = 1'b1;
          flag_new    = {3'b000, ~|mul_sum, mul_sum[WIDTH-1]};
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A direct load always beats an op's flag write.
    if (bus.psr_load) begin
      psr_d = bus.psr_din;
    end else if (flag_wr) begin
      psr_d = flag_new;
    end else begin
      psr_d = psr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      result_q    <= '0;
      psr_q       <= '0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      psr_q       <= psr_d;
      out_valid_q <= out_valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_psr.sv
// tb_alu_psr: directed test-plan steps followed by randomized operations, checked
// against an integer-arithmetic reference model of the ALU and PSR.
module tb_alu_psr;
  localparam int unsigned W    = 16;
  localparam int unsigned MASK = 32'h0000_FFFF;

  localparam logic [4:0] AND_ = 5'b00001, OR_ = 5'b00010, XOR_ = 5'b00011, NOT_ = 5'b00100;
  localparam logic [4:0] ADD = 5'b00101, ADDU = 5'b00110, ADDC = 5'b00111, ADDCU = 5'b01111;
  localparam logic [4:0] SUB = 5'b01001, CMP = 5'b01011, LSH = 5'b01100, RSH = 5'b10011;
  localparam logic [4:0] ARSH = 5'b10111, MUL = 5'b10000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [4:0]  m_psr = '0;
  int unsigned m_res = 0;

  always #5 clk = ~clk;

  alu_psr_if #(.WIDTH(W)) bus ();

  alu_psr #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int to_s(input int unsigned v);
    return (v >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  // Reference: result and the PSR value after the op (unchanged when the op writes no flags).
  function automatic void ref_op(input logic [4:0] op, input int unsigned a, input int unsigned b,
                                 input logic [4:0] psr, output int unsigned res,
                                 output logic [4:0] fl);
    int unsigned t;
    int          st;
    int unsigned c;
    c   = (op == ADDC || op == ADDCU) ? int'(psr[4]) : 0;
    res = 0;
    fl  = psr;
    case (op)
      ADD, ADDC: begin
        t   = a + b + c;
        res = t & MASK;
        st  = to_s(a) + to_s(b) + int'(c);
        fl  = {t > MASK, 1'b0, (st > 32767 || st < -32768), res == 0, res >= 32768};
      end
      ADDU, ADDCU: res = (a + b + c) & MASK;
      SUB: begin
        res = (a - b) & MASK;
        st  = to_s(a) - to_s(b);
        fl  = {a < b, 1'b0, (st > 32767 || st < -32768), res == 0, res >= 32768};
      end
      CMP: fl = {1'b0, a < b, 1'b0, a == b, to_s(a) < to_s(b)};
      AND_: res = a & b;
      OR_:  res = a | b;
      XOR_: res = a ^ b;
      NOT_: res = ~a & MASK;
      LSH:  res = (b >= W) ? 0 : (a << b) & MASK;
      RSH:  res = (b >= W) ? 0 : a >> b;
      ARSH: begin
        if (b >= W) res = (to_s(a) < 0) ? MASK : 0;
        else        res = int'(to_s(a) >>> b) & MASK;
      end
      MUL: begin
        res = (a * b) & MASK;
        fl  = {3'b000, res == 0, res >= 32768};
      end
      default: ;
    endcase
  endfunction

  // One clocked step for a non-MUL request (or an idle cycle), checked after the edge.
  task automatic step(input string tag, input logic iv, input logic [4:0] op,
                      input int unsigned a, input int unsigned b,
                      input logic ld, input logic [4:0] din);
    int unsigned r;
    logic [4:0]  f;
    bus.in_valid = iv;
    bus.opcode   = op;
    bus.a        = a[W-1:0];
    bus.b        = b[W-1:0];
    bus.psr_load = ld;
    bus.psr_din  = din;
    ref_op(op, a, b, m_psr, r, f);
    @(posedge clk); #1;
    if (iv) begin
      m_res = r;
      m_psr = ld ? din : f;
    end else if (ld) begin
      m_psr = din;
    end
    check({tag, "_ov"}, {31'd0, bus.out_valid}, {31'd0, iv});
    check({tag, "_res"}, {16'd0, bus.result}, m_res);
    check({tag, "_flags"}, {27'd0, bus.flags}, {27'd0, m_psr});
  endtask

  // MUL with an ignored ADD held on the bus during the run and an optional psr_load
  // on cycle ld_cyc (1..W-1; 0 = none).
  task automatic run_mul(input string tag, input int unsigned a, input int unsigned b,
                         input int ld_cyc, input logic [4:0] din);
    int unsigned r;
    logic [4:0]  f;
    int          k;
    int          low;
    ref_op(MUL, a, b, m_psr, r, f);
    bus.in_valid = 1'b1;
    bus.opcode   = MUL;
    bus.a        = a[W-1:0];
    bus.b        = b[W-1:0];
    bus.psr_load = 1'b0;
    @(posedge clk); #1;
    bus.opcode = ADD;
    bus.a      = 16'h1111;
    bus.b      = 16'h2222;
    k   = 1;
    low = 0;
    while (!bus.out_valid && k < 40) begin
      if (!bus.in_ready) low++;
      bus.psr_load = (k == ld_cyc);
      bus.psr_din  = din;
      @(posedge clk); #1;
      k++;
    end
    bus.in_valid = 1'b0;
    bus.psr_load = 1'b0;
    m_res = r;
    m_psr = (ld_cyc == W - 1) ? din : f;
    check({tag, "_lat"}, k, W);
    check({tag, "_busy"}, low, W - 1);
    check({tag, "_rdy"}, {31'd0, bus.in_ready}, 1);
    check({tag, "_res"}, {16'd0, bus.result}, m_res);
    check({tag, "_flags"}, {27'd0, bus.flags}, {27'd0, m_psr});
    step({tag, "_after"}, 1'b0, ADD, 0, 0, 1'b0, 5'd0);
  endtask

  logic [4:0] ops[16] = '{ADD, ADDU, ADDC, ADDCU, SUB, CMP, AND_, OR_, XOR_, NOT_,
                          LSH, RSH, ARSH, MUL, 5'b00000, 5'b11010};

  initial begin
    int pulses;
    bus.in_valid = 1'b0;
    bus.opcode   = '0;
    bus.a        = '0;
    bus.b        = '0;
    bus.psr_load = 1'b0;
    bus.psr_din  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_res", {16'd0, bus.result}, 0);
    check("rst_flags", {27'd0, bus.flags}, 0);
    check("rst_ov", {31'd0, bus.out_valid}, 0);
    check("rst_rdy", {31'd0, bus.in_ready}, 1);

    step("add_ovf", 1'b1, ADD, 16'h7FFF, 16'h0001, 1'b0, 5'd0);
    check("tp_add_res", {16'd0, bus.result}, 16'h8000);
    check("tp_add_flags", {27'd0, bus.flags}, 5'b00101);
    step("add_carry", 1'b1, ADD, 16'hFFFF, 16'h0001, 1'b0, 5'd0);
    check("tp_carry_flags", {27'd0, bus.flags}, 5'b10010);
    step("addc_fwd", 1'b1, ADDC, 16'h0001, 16'h0001, 1'b0, 5'd0);
    check("tp_addc_res", {16'd0, bus.result}, 16'h0003);
    check("tp_addc_flags", {27'd0, bus.flags}, 5'b00000);
    step("cmp", 1'b1, CMP, 16'hFFFF, 16'h0001, 1'b0, 5'd0);
    check("tp_cmp_flags", {27'd0, bus.flags}, 5'b00001);
    step("sub", 1'b1, SUB, 16'h8000, 16'h0001, 1'b0, 5'd0);
    check("tp_sub_flags", {27'd0, bus.flags}, 5'b00100);
    step("preload", 1'b0, ADD, 0, 0, 1'b1, 5'b10000);
    step("addcu", 1'b1, ADDCU, 16'h0001, 16'h0001, 1'b0, 5'd0);
    check("tp_addcu_res", {16'd0, bus.result}, 16'h0003);
    check("tp_addcu_flags", {27'd0, bus.flags}, 5'b10000);
    step("arsh_big", 1'b1, ARSH, 16'h8000, 20, 1'b0, 5'd0);
    check("tp_arsh_res", {16'd0, bus.result}, 16'hFFFF);
    step("ld_wins", 1'b1, SUB, 16'h0000, 16'h0001, 1'b1, 5'b01010);
    step("unknown", 1'b1, 5'b11111, 16'h1234, 16'h5678, 1'b0, 5'd0);

    run_mul("mul_tp", 16'h0123, 16'h0010, 0, 5'd0);
    check("tp_mul_res", {16'd0, bus.result}, 16'h1230);
    run_mul("mul_ld_mid", 16'h00FF, 16'h0101, 5, 5'b11111);
    run_mul("mul_ld_last", 16'h8001, 16'h0003, W - 1, 5'b01101);

    // Reset five cycles into a multiply aborts it silently.
    bus.in_valid = 1'b1;
    bus.opcode   = MUL;
    bus.a        = 16'h0003;
    bus.b        = 16'h0005;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      pulses += int'(bus.out_valid);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_res = 0;
    m_psr = '0;
    check("abort_res", {16'd0, bus.result}, 0);
    check("abort_flags", {27'd0, bus.flags}, 0);
    check("abort_rdy", {31'd0, bus.in_ready}, 1);
    repeat (20) begin
      pulses += int'(bus.out_valid);
      @(posedge clk); #1;
    end
    check("abort_no_pulse", pulses, 0);
    step("and_after", 1'b1, AND_, 16'h00FF, 16'h0F0F, 1'b0, 5'd0);
    check("tp_and_res", {16'd0, bus.result}, 16'h000F);

    for (int i = 0; i < 300; i++) begin
      logic [4:0]  op;
      int unsigned a;
      int unsigned b;
      op = ops[$urandom_range(0, 15)];
      a  = $urandom & MASK;
      b  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20) : ($urandom & MASK);
      if (op == MUL) begin
        run_mul("rnd_mul", a, b, $urandom_range(0, W - 1), 5'($urandom));
      end else begin
        step("rnd", $urandom_range(0, 3) != 0, op, a, b, $urandom_range(0, 7) == 0,
             5'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
